bus_interrupt_controller: RTL and testbench
===========================================

Name: bus_interrupt_controller

Overview:
- Parametrised interrupt controller on the shared 8-bit data/address bus, placed between up to 8 peripheral interrupt sources and one CPU interrupt line.
- It replaces the hard-wired one-raise/ack-pair-per-peripheral scheme.
- Adds per-source edge/level mode, masking, fixed priority, a readable vector, an in-service latch with end-of-interrupt, and forwards acknowledges back to each source.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8).
- BASE_ADDR, 8'hC0, bus address of register offset 0; decodes BASE_ADDR..BASE_ADDR+5.
- MODE_RESET, 8'hFF, reset value of MODE (1 = edge).

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- BUS_DATA  inout  8  shared data bus; driven only during a read of this block, otherwise high-Z
- BUS_ADDR  in  8  shared address bus
- BUS_WE  in  1  bus write enable
- SRC_RAISE  in  NUM_SRC  per-source interrupt request
- SRC_ACK  out  NUM_SRC  one-cycle acknowledge pulse per source
- CPU_IRQ_RAISE  out  1  interrupt request to processor
- CPU_IRQ_ACK  in  1  one-cycle acknowledge from processor

Behaviour:
- Reset: RESET==0 at a clock edge clears PENDING, MASK, ACTIVE, src_prev, SRC_ACK, CPU_IRQ_RAISE and the bus output enable; MODE←MODE_RESET.
- Register map (offset, access):
  - +0 PENDING (R; write-1-to-clear)
  - +1 MASK (R/W, 1 = enabled)
  - +2 MODE (R/W)
  - +3 VECTOR (R): bit7 = any masked pending; bits2:0 = lowest set index of PENDING&MASK; 0 when none
  - +4 EOI (W, any data clears ACTIVE)
  - +5 ACTIVE (R): bit7 = valid; bits2:0 = index in service
- Bits ≥ NUM_SRC in PENDING/MASK/MODE read 0 and ignore writes.
- Write: decoded in the cycle BUS_WE=1 with a matching address; takes effect at that clock edge.
- Read: address match with BUS_WE=0 registers the data and asserts output enable for exactly the next cycle. Latency is 1 cycle. Reads have no side effects.
- Edge mode: pending[i] sets when SRC_RAISE[i]=1 and src_prev[i]=0.
- Level mode: pending[i] sets while SRC_RAISE[i]=1, except in the 2 cycles after SRC_ACK[i] pulses.
- Clear/set collision: a set condition and a clear (W1C or ack) on the same bit in the same cycle leave the bit set.
- Priority: fixed, index 0 highest.
- CPU_IRQ_RAISE is registered: 1 when (PENDING&MASK)≠0 and ACTIVE.valid=0.
- On CPU_IRQ_ACK=1 with VECTOR.valid=1 and ACTIVE.valid=0, at that edge:
  - ACTIVE←{1, VECTOR index}
  - that PENDING bit clears
  - SRC_ACK[index] pulses high for the following cycle only
  - CPU_IRQ_RAISE drops the following cycle
- CPU_IRQ_ACK with nothing pending, or while ACTIVE is valid: ignored, no SRC_ACK.
- EOI clears ACTIVE. CPU_IRQ_RAISE reasserts one cycle later if anything masked is still pending.
- EOI and a new CPU_IRQ_ACK in the same cycle: the ACK is ignored.
- MASK only gates raise/vector. Masked sources still latch PENDING.
- Reset mid-handshake: any SRC_ACK pulse in flight is suppressed, and ACTIVE is lost.

Decomposition:
- Shared package holds:
  - register offset constants (PENDING, MASK, MODE, VECTOR, EOI, ACTIVE)
  - VECTOR/ACTIVE field positions (valid bit 7, index bits 2:0)
  - MAX_SRC = 8
- One sub-module: irq_priority_encoder. It is combinational, parametrised by NUM_SRC, and outputs valid plus the 3-bit lowest set index.
- Channel state stays inline in a generate loop.

Test Plan:
- Reset with RESET=0 for 2 cycles, then read +2 and +1 → MODE reads 8'hFF, MASK reads 8'h00. BUS_DATA is high-Z except the cycle after each read. CPU_IRQ_RAISE=0.
- Write MASK=8'h0A. Pulse SRC_RAISE[3] then [1]. Read VECTOR → 8'h81, and CPU_IRQ_RAISE=1. Pulse CPU_IRQ_ACK → ACTIVE reads 8'h81, SRC_ACK[1] high for exactly 1 cycle, PENDING reads 8'h08, raise=0.
- Continuing that state, write EOI → raise=1 within 1 cycle. Ack → ACTIVE 8'h83, SRC_ACK[3] pulses. EOI → raise stays 0.
- Write MODE=8'h00 and MASK=8'h01. Hold SRC_RAISE[0]=1 until SRC_ACK[0], then release within 2 cycles → exactly one interrupt, PENDING=0 afterwards.
- Write PENDING=8'h04 (W1C) in the same cycle as a rising edge on SRC_RAISE[2] → PENDING bit 2 stays set.
- With SRC_RAISE[5] rising and MASK=0 → PENDING=8'h20, VECTOR=8'h00, raise=0. Then write MASK=8'h20 → raise=1 next cycle.

Source files
------------

// File: rtl/bus_interrupt_controller_pkg.sv
// ---------------------------------------------------------------------------
// bus_interrupt_controller_pkg
// Shared definitions for the bus interrupt controller:
//   - register offsets relative to BASE_ADDR
//   - VECTOR / ACTIVE field positions (valid bit, index field)
//   - MAX_SRC, the widest source count the register map can hold
//   - pack_vec(), which builds a VECTOR/ACTIVE read byte
// ---------------------------------------------------------------------------
package bus_interrupt_controller_pkg;

   localparam int MAX_SRC = 8;

   // Register offsets
   localparam logic [2:0] OFS_PENDING = 3'd0;
   localparam logic [2:0] OFS_MASK    = 3'd1;
   localparam logic [2:0] OFS_MODE    = 3'd2;
   localparam logic [2:0] OFS_VECTOR  = 3'd3;
   localparam logic [2:0] OFS_EOI     = 3'd4;
   localparam logic [2:0] OFS_ACTIVE  = 3'd5;
   localparam logic [7:0] NUM_REGS    = 8'd6;

   // VECTOR / ACTIVE field layout
   localparam int VALID_BIT = 7;
   localparam int IDX_MSB   = 2;
   localparam int IDX_LSB   = 0;

   function automatic logic [7:0] pack_vec(input logic valid, input logic [2:0] idx);
      logic [7:0] r;
      r                  = 8'h00;
      r[VALID_BIT]       = valid;
      r[IDX_MSB:IDX_LSB] = idx;
      return r;
   endfunction

endpackage

// File: rtl/bus_interrupt_controller_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
// Combinational fixed-priority encoder, index 0 highest.
// Ports:
//   req   in  NUM_SRC  request vector (already masked by the caller)
//   valid out 1        any request set
//   idx   out 3        lowest set index, 0 when nothing is set
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
   parameter int NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [2:0]         idx
);

   // Scan from the top down so the last hit (lowest index) wins.
   always_comb begin
      valid = 1'b0;
      idx   = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/bus_interrupt_controller.sv
// ---------------------------------------------------------------------------
// bus_interrupt_controller
// Collects up to NUM_SRC peripheral interrupt requests (edge or level per
// source), masks and prioritises them, raises one CPU interrupt line, and
// forwards the CPU acknowledge back to the winning source.
// Ports:
//   CLK           in    1        system clock, rising edge
//   RESET         in    1        synchronous, active-low reset
//   BUS_DATA      inout 8        shared data bus, driven only the cycle after a read
//   BUS_ADDR      in    8        shared address bus
//   BUS_WE        in    1        bus write enable
//   SRC_RAISE     in    NUM_SRC  per-source request
//   SRC_ACK       out   NUM_SRC  one-cycle acknowledge per source
//   CPU_IRQ_RAISE out   1        interrupt request to CPU (registered)
//   CPU_IRQ_ACK   in    1        one-cycle acknowledge from CPU
// ---------------------------------------------------------------------------
module bus_interrupt_controller
   import bus_interrupt_controller_pkg::*;
#(
   parameter int         NUM_SRC    = 8,
   parameter logic [7:0] BASE_ADDR  = 8'hC0,
   parameter logic [7:0] MODE_RESET = 8'hFF
) (
   input  logic               CLK,
   input  logic               RESET,
   inout  wire  [7:0]         BUS_DATA,
   input  logic [7:0]         BUS_ADDR,
   input  logic               BUS_WE,
   input  logic [NUM_SRC-1:0] SRC_RAISE,
   output logic [NUM_SRC-1:0] SRC_ACK,
   output logic               CPU_IRQ_RAISE,
   input  logic               CPU_IRQ_ACK
);

   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] mode_q, mode_d;
   logic [NUM_SRC-1:0] src_prev_q;
   logic [NUM_SRC-1:0] src_ack_q, src_ack_d;
   logic               active_valid_q, active_valid_d;
   logic [2:0]         active_idx_q, active_idx_d;
   logic               irq_q, irq_d;
   logic               rd_oe_q, rd_oe_d;
   logic [7:0]         rd_data_q, rd_data_d;

   logic [7:0]         offset;
   logic               hit, rd_en, wr_pending, wr_mask, wr_mode, wr_eoi;
   logic [NUM_SRC-1:0] wr_bits;
   logic               vec_valid;
   logic [2:0]         vec_idx;
   logic               ack_fire;
   logic [MAX_SRC-1:0] pending_rd, mask_rd, mode_rd;

   // Address decode: wrap-safe subtraction, then a range check.
   assign offset     = BUS_ADDR - BASE_ADDR;
   assign hit        = (offset < NUM_REGS);
   assign rd_en      = hit & ~BUS_WE;
   assign wr_pending = hit & BUS_WE & (offset[2:0] == OFS_PENDING);
   assign wr_mask    = hit & BUS_WE & (offset[2:0] == OFS_MASK);
   assign wr_mode    = hit & BUS_WE & (offset[2:0] == OFS_MODE);
   assign wr_eoi     = hit & BUS_WE & (offset[2:0] == OFS_EOI);
   assign wr_bits    = BUS_DATA[NUM_SRC-1:0];

   irq_priority_encoder #(.NUM_SRC(NUM_SRC)) u_prio (
      .req   (pending_q & mask_q),
      .valid (vec_valid),
      .idx   (vec_idx)
   );

   // An EOI in the same cycle wins over a new acknowledge.
   assign ack_fire = CPU_IRQ_ACK & vec_valid & ~active_valid_q & ~wr_eoi;

   always_comb begin
      src_ack_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ack_d[i] = ack_fire && (vec_idx == 3'(i));
      end
   end

   // Per-channel pending latch. The level hold-off counter blocks re-latching
   // on the ack edge, in the SRC_ACK pulse cycle and in the 2 cycles after,
   // so a source that drops its request promptly is serviced exactly once.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_ch
         logic [1:0] hold_q, hold_d;
         logic       set_edge, set_level, set_any, clr_any;

         assign set_edge  = SRC_RAISE[gi] & ~src_prev_q[gi];
         assign set_level = SRC_RAISE[gi] & ~src_ack_d[gi] & (hold_q == 2'd0);
         assign set_any   = mode_q[gi] ? set_edge : set_level;
         assign clr_any   = (wr_pending & wr_bits[gi]) | src_ack_d[gi];
         // Set beats clear on a collision.
         assign pending_d[gi] = set_any | (pending_q[gi] & ~clr_any);
         assign hold_d = src_ack_d[gi]      ? 2'd3 :
                         (hold_q != 2'd0)   ? hold_q - 2'd1 : 2'd0;

         always_ff @(posedge CLK) begin
            if (!RESET) hold_q <= 2'd0;
            else        hold_q <= hold_d;
         end
      end
   endgenerate

   always_comb begin
      mask_d         = wr_mask ? wr_bits : mask_q;
      mode_d         = wr_mode ? wr_bits : mode_q;
      active_valid_d = active_valid_q;
      active_idx_d   = active_idx_q;
      if (wr_eoi) begin
         active_valid_d = 1'b0;
         active_idx_d   = 3'd0;
      end else if (ack_fire) begin
         active_valid_d = 1'b1;
         active_idx_d   = vec_idx;
      end
      // Computed from next state so the line drops right after an ack and
      // rises right after an EOI or mask write.
      irq_d = (|(pending_d & mask_d)) & ~active_valid_d;
   end

   // Zero-extend channel registers to the full bus width for reads.
   always_comb begin
      pending_rd = '0;
      mask_rd    = '0;
      mode_rd    = '0;
      pending_rd[NUM_SRC-1:0] = pending_q;
      mask_rd[NUM_SRC-1:0]    = mask_q;
      mode_rd[NUM_SRC-1:0]    = mode_q;
   end

   always_comb begin
      rd_oe_d   = rd_en;
      rd_data_d = 8'h00;
      if (rd_en) begin
         case (offset[2:0])
            OFS_PENDING: rd_data_d = pending_rd;
            OFS_MASK:    rd_data_d = mask_rd;
            OFS_MODE:    rd_data_d = mode_rd;
            OFS_VECTOR:  rd_data_d = pack_vec(vec_valid, vec_idx);
            OFS_ACTIVE:  rd_data_d = pack_vec(active_valid_q, active_idx_q);
            default:     rd_data_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         pending_q      <= '0;
         mask_q         <= '0;
         mode_q         <= MODE_RESET[NUM_SRC-1:0];
         src_prev_q     <= '0;
         src_ack_q      <= '0;
         active_valid_q <= 1'b0;
         active_idx_q   <= 3'd0;
         irq_q          <= 1'b0;
         rd_oe_q        <= 1'b0;
         rd_data_q      <= 8'h00;
      end else begin
         pending_q      <= pending_d;
         mask_q         <= mask_d;
         mode_q         <= mode_d;
         src_prev_q     <= SRC_RAISE;
         src_ack_q      <= src_ack_d;
         active_valid_q <= active_valid_d;
         active_idx_q   <= active_idx_d;
         irq_q          <= irq_d;
         rd_oe_q        <= rd_oe_d;
         rd_data_q      <= rd_data_d;
      end
   end

   assign BUS_DATA      = rd_oe_q ? rd_data_q : 8'hzz;
   assign SRC_ACK       = src_ack_q;
   assign CPU_IRQ_RAISE = irq_q;

endmodule

// File: tb/tb_bus_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_bus_interrupt_controller
// Directed scenarios followed by randomized traffic, every cycle compared
// against a cycle-level behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_bus_interrupt_controller;

   localparam logic [7:0] BASE   = 8'hC0;
   localparam logic [7:0] IDLE_A = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] addr;
   logic       we;
   logic [7:0] tb_drv;
   logic       tb_oe;
   logic [7:0] raise;
   logic       cpu_ack;
   logic [7:0] src_ack;
   logic       cpu_irq;
   wire  [7:0] bus_data;

   assign bus_data = tb_oe ? tb_drv : 8'hzz;

   always #5 clk = ~clk;

   bus_interrupt_controller #(
      .NUM_SRC    (8),
      .BASE_ADDR  (BASE),
      .MODE_RESET (8'hFF)
   ) dut (
      .CLK           (clk),
      .RESET         (rst_n),
      .BUS_DATA      (bus_data),
      .BUS_ADDR      (addr),
      .BUS_WE        (we),
      .SRC_RAISE     (raise),
      .SRC_ACK       (src_ack),
      .CPU_IRQ_RAISE (cpu_irq),
      .CPU_IRQ_ACK   (cpu_ack)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_pend, m_mask, m_mode, m_prev, m_srcack;
   int         m_last_ack[8];
   bit         m_act_v;
   int         m_act_idx;
   bit         m_irq, m_oe;
   logic [7:0] m_rd;
   int         cyc = 0;

   function automatic int winner();
      for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) return i;
      return -1;
   endfunction

   task automatic model_edge();
      int         v, off;
      bit         hit, eoi, fire, setc, clr;
      logic [7:0] np;
      cyc++;
      if (!rst_n) begin
         m_pend = 0; m_mask = 0; m_mode = 8'hFF; m_prev = 0; m_srcack = 0;
         m_act_v = 0; m_act_idx = 0; m_irq = 0; m_oe = 0;
         for (int i = 0; i < 8; i++) m_last_ack[i] = -100;
         return;
      end
      off  = int'(addr) - int'(BASE);
      hit  = (off >= 0) && (off < 6);
      v    = winner();
      m_oe = hit && !we;
      if (m_oe) begin
         case (off)
            0: m_rd = m_pend;
            1: m_rd = m_mask;
            2: m_rd = m_mode;
            3: m_rd = (v >= 0) ? (8'h80 | 8'(v)) : 8'h00;
            5: m_rd = m_act_v ? (8'h80 | 8'(m_act_idx)) : 8'h00;
            default: m_rd = 8'h00;
         endcase
      end
      eoi  = hit && we && off == 4;
      fire = cpu_ack && (v >= 0) && !m_act_v && !eoi;
      for (int i = 0; i < 8; i++) begin
         if (m_mode[i]) setc = raise[i] && !m_prev[i];
         else           setc = raise[i] && !(fire && v == i) && (cyc - m_last_ack[i] > 3);
         clr   = (hit && we && off == 0 && tb_drv[i]) || (fire && v == i);
         np[i] = setc || (m_pend[i] && !clr);
      end
      if (hit && we && off == 1) m_mask = tb_drv;
      if (hit && we && off == 2) m_mode = tb_drv;
      m_srcack = 0;
      if (fire) begin
         m_srcack[v]   = 1'b1;
         m_last_ack[v] = cyc;
         m_act_v       = 1;
         m_act_idx     = v;
      end
      if (eoi) begin
         m_act_v   = 0;
         m_act_idx = 0;
      end
      m_pend = np;
      m_prev = raise;
      m_irq  = ((m_pend & m_mask) != 0) && !m_act_v;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_val("irq", 32'(cpu_irq), 32'(m_irq));
      check_val("src_ack", 32'(src_ack), 32'(m_srcack));
      if (m_oe) check_val("bus_rd", 32'(bus_data), 32'(m_rd));
   endtask

   task automatic wr(input int off, input logic [7:0] data);
      addr = BASE + 8'(off); we = 1'b1; tb_drv = data; tb_oe = 1'b1;
      cycle();
      addr = IDLE_A; we = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic rd(input int off, output logic [7:0] val);
      addr = BASE + 8'(off); we = 1'b0;
      cycle();
      val  = bus_data;
      addr = IDLE_A;
      cycle();
   endtask

   logic [7:0] rv;
   int         acks0, k, r;
   bit         got;

   initial begin
      rst_n = 1'b0; addr = IDLE_A; we = 1'b0; tb_drv = 8'h00; tb_oe = 1'b0;
      raise = 8'h00; cpu_ack = 1'b0;
      for (int i = 0; i < 8; i++) m_last_ack[i] = -100;

      // Reset and defaults
      cycle(); cycle();
      rst_n = 1'b1;
      rd(2, rv); check_val("mode_rst", 32'(rv), 32'h0FF);
      rd(1, rv); check_val("mask_rst", 32'(rv), 32'h000);
      check_val("irq_rst", 32'(cpu_irq), 32'h0);

      // Priority, ack, SRC_ACK forwarding
      wr(1, 8'h0A);
      raise = 8'h08; cycle();
      raise = 8'h02; cycle();
      raise = 8'h00;
      rd(3, rv); check_val("vector_81", 32'(rv), 32'h81);
      check_val("irq_up", 32'(cpu_irq), 32'h1);
      cpu_ack = 1'b1; cycle(); cpu_ack = 1'b0;
      check_val("srcack1", 32'(src_ack), 32'h02);
      check_val("irq_drop", 32'(cpu_irq), 32'h0);
      cycle();
      check_val("srcack1_end", 32'(src_ack), 32'h00);
      rd(5, rv); check_val("active_81", 32'(rv), 32'h81);
      rd(0, rv); check_val("pend_08", 32'(rv), 32'h08);

      // EOI, second service
      wr(4, 8'h00);
      check_val("irq_after_eoi", 32'(cpu_irq), 32'h1);
      cpu_ack = 1'b1; cycle(); cpu_ack = 1'b0;
      check_val("srcack3", 32'(src_ack), 32'h08);
      cycle();
      rd(5, rv); check_val("active_83", 32'(rv), 32'h83);
      wr(4, 8'h5A);
      check_val("irq_idle", 32'(cpu_irq), 32'h0);

      // Level mode, single service
      wr(2, 8'h00); wr(1, 8'h01);
      raise = 8'h01; got = 0; acks0 = 0;
      for (k = 0; k < 20 && !got; k++) begin
         cpu_ack = cpu_irq;
         cycle();
         cpu_ack = 1'b0;
         if (src_ack[0]) begin got = 1; acks0++; end
      end
      check_val("lvl_ack_seen", 32'(got), 32'h1);
      cycle();
      raise = 8'h00;
      wr(4, 8'h00);
      for (k = 0; k < 4; k++) begin
         cpu_ack = cpu_irq; cycle(); cpu_ack = 1'b0;
         if (src_ack[0]) acks0++;
      end
      check_val("lvl_one_irq", 32'(acks0), 32'h1);
      rd(0, rv); check_val("lvl_pend_0", 32'(rv), 32'h00);
      wr(4, 8'h00);

      // W1C colliding with a rising edge
      wr(2, 8'hFF);
      raise = 8'h04; wr(0, 8'h04); raise = 8'h00;
      rd(0, rv); check_val("w1c_collide", 32'(rv), 32'h04);
      wr(0, 8'hFF);
      rd(0, rv); check_val("w1c_clear", 32'(rv), 32'h00);

      // Masked sources still latch
      wr(1, 8'h00);
      raise = 8'h20; cycle(); raise = 8'h00;
      rd(0, rv); check_val("masked_pend", 32'(rv), 32'h20);
      rd(3, rv); check_val("masked_vec", 32'(rv), 32'h00);
      check_val("masked_irq", 32'(cpu_irq), 32'h0);
      wr(1, 8'h20);
      check_val("unmask_irq", 32'(cpu_irq), 32'h1);

      // Reset coinciding with an ack suppresses SRC_ACK
      cpu_ack = 1'b1; rst_n = 1'b0; cycle(); cpu_ack = 1'b0; rst_n = 1'b1;
      check_val("rst_ack_supp", 32'(src_ack), 32'h00);
      rd(5, rv); check_val("rst_active", 32'(rv), 32'h00);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         rst_n   = ($urandom_range(0, 99) != 0);
         raise   = raise ^ 8'($urandom & $urandom);
         cpu_ack = (cpu_irq && $urandom_range(0, 1) == 1) || ($urandom_range(0, 15) == 0);
         we = 1'b0; tb_oe = 1'b0; addr = IDLE_A;
         r = $urandom_range(0, 9);
         if (r <= 2) begin
            addr = BASE + 8'($urandom_range(0, 5));
         end else if (r <= 4 && !m_oe) begin
            we = 1'b1; tb_oe = 1'b1;
            tb_drv = 8'($urandom);
            addr = (m_act_v && $urandom_range(0, 3) == 0) ? BASE + 8'd4
                                                         : BASE + 8'($urandom_range(0, 5));
         end
         cycle();
      end
      we = 1'b0; tb_oe = 1'b0; addr = IDLE_A;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
